// File: rtl/restador_punto_flotante_pkg.sv
// ============================================================================
// Module      : fp_pkg
// Description : Shared single-precision float types, constants and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam logic [4:0] DIFF_MAX = 5'd25;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } float32_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ALIGN = 3'd2,
        OPER  = 3'd3,
        NORM  = 3'd4,
        DONE  = 3'd5
    } estado_t;

endpackage

`default_nettype wire

// File: rtl/desempaquetador_fp.sv
// ============================================================================
// Module      : desempaquetador_fp
// Description : Unpacks two floats with hidden bit, flushes denormals, orders
//               them by magnitude and gives the clamped exponent distance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module desempaquetador_fp
    import fp_pkg::*;
(
    input  float32_t         op_x_i,
    input  float32_t         op_y_i,
    output logic             sign_M_o,
    output logic [EXP_W-1:0] exp_M_o,
    output logic [MAN_W:0]   man_M_o,
    output logic             sign_m_o,
    output logic [MAN_W:0]   man_m_o,
    output logic [4:0]       diff_o,
    output logic             inf_o
);

    logic [MAN_W:0]   w_man_x;
    logic [MAN_W:0]   w_man_y;
    logic [EXP_W-1:0] w_exp_m;
    logic [EXP_W-1:0] w_ediff;
    logic             w_x_ge;

    // A zero exponent carries no hidden bit, so the whole operand becomes zero.
    assign w_man_x = (op_x_i.exp == '0) ? '0 : {1'b1, op_x_i.man};
    assign w_man_y = (op_y_i.exp == '0) ? '0 : {1'b1, op_y_i.man};

    assign w_x_ge  = {op_x_i.exp, w_man_x} >= {op_y_i.exp, w_man_y};

    assign sign_M_o = w_x_ge ? op_x_i.sign : op_y_i.sign;
    assign exp_M_o  = w_x_ge ? op_x_i.exp  : op_y_i.exp;
    assign man_M_o  = w_x_ge ? w_man_x     : w_man_y;
    assign sign_m_o = w_x_ge ? op_y_i.sign : op_x_i.sign;
    assign man_m_o  = w_x_ge ? w_man_y     : w_man_x;
    assign w_exp_m  = w_x_ge ? op_y_i.exp  : op_x_i.exp;

    assign w_ediff = exp_M_o - w_exp_m;
    assign diff_o  = (w_ediff > EXP_W'(DIFF_MAX)) ? DIFF_MAX : w_ediff[4:0];

    assign inf_o = (op_x_i.exp == EXP_W'(EXP_MAX)) || (op_y_i.exp == EXP_W'(EXP_MAX));

endmodule

`default_nettype wire

// File: rtl/restador_punto_flotante.sv
// ============================================================================
// Module      : restador_punto_flotante
// Description : Multi-cycle IEEE-754 single-precision subtractor (a - b),
//               flush-to-zero, truncation. Optional macro MANUAL_STEP_EN adds
//               a step input that gates every non-IDLE state transition.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module restador_punto_flotante
    import fp_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
`ifdef MANUAL_STEP_EN
    input  logic         step,
`endif
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         overflow,
    output logic         zero,
    output logic [2:0]   estado
);

    estado_t          state_q;
    float32_t         opa_q;
    float32_t         opb_q;
    logic             sign_q;
    logic             eff_add_q;
    logic [EXP_W-1:0] exp_q;
    logic [MAN_W:0]   man_M_q;
    logic [MAN_W:0]   man_m_q;
    logic [4:0]       diff_q;
    logic [MAN_W+1:0] sum_q;
    logic             ovf_q;
    logic             zf_q;
    logic             busy_q;
    logic             done_q;
    logic [N-1:0]     result_q;
    logic             overflow_q;
    logic             zero_q;

    logic             w_sign_M;
    logic [EXP_W-1:0] w_exp_M;
    logic [MAN_W:0]   w_man_M;
    logic             w_sign_m;
    logic [MAN_W:0]   w_man_m;
    logic [4:0]       w_diff;
    logic             w_inf;
    logic             w_adv;
    logic [MAN_W+1:0] sum_d;
    logic [MAN_W+1:0] norm_sum_d;
    logic [EXP_W-1:0] norm_exp_d;

    desempaquetador_fp u_desempaquetador (
        .op_x_i   (opa_q),
        .op_y_i   (opb_q),
        .sign_M_o (w_sign_M),
        .exp_M_o  (w_exp_M),
        .man_M_o  (w_man_M),
        .sign_m_o (w_sign_m),
        .man_m_o  (w_man_m),
        .diff_o   (w_diff),
        .inf_o    (w_inf)
    );

`ifdef MANUAL_STEP_EN
    assign w_adv = (state_q == IDLE) || step;
`else
    assign w_adv = 1'b1;
`endif

    // M is never smaller than the aligned m, so the difference cannot wrap.
    assign sum_d = eff_add_q ? ({1'b0, man_M_q} + {1'b0, man_m_q})
                             : ({1'b0, man_M_q} - {1'b0, man_m_q});

    assign norm_sum_d = sum_q[MAN_W+1] ? (sum_q >> 1) : (sum_q << 1);
    assign norm_exp_d = sum_q[MAN_W+1] ? (exp_q + 8'd1) : (exp_q - 8'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            opa_q      <= '0;
            opb_q      <= '0;
            sign_q     <= 1'b0;
            eff_add_q  <= 1'b0;
            exp_q      <= '0;
            man_M_q    <= '0;
            man_m_q    <= '0;
            diff_q     <= '0;
            sum_q      <= '0;
            ovf_q      <= 1'b0;
            zf_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (w_adv) begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            opa_q   <= a;
                            opb_q   <= {~b[N-1], b[N-2:0]};
                            busy_q  <= 1'b1;
                            state_q <= LOAD;
                        end
                    end
                    LOAD: begin
                        result_q   <= '0;
                        overflow_q <= 1'b0;
                        zero_q     <= 1'b0;
                        ovf_q      <= 1'b0;
                        zf_q       <= 1'b0;
                        sign_q     <= w_sign_M;
                        exp_q      <= w_exp_M;
                        man_M_q    <= w_man_M;
                        man_m_q    <= w_man_m;
                        diff_q     <= w_diff;
                        eff_add_q  <= (w_sign_M == w_sign_m);
                        if (w_inf) begin
                            ovf_q   <= 1'b1;
                            state_q <= DONE;
                        end else if (w_diff != 5'd0) begin
                            state_q <= ALIGN;
                        end else begin
                            state_q <= OPER;
                        end
                    end
                    ALIGN: begin
                        man_m_q <= man_m_q >> 1;
                        diff_q  <= diff_q - 5'd1;
                        if (diff_q == 5'd1) state_q <= OPER;
                    end
                    OPER: begin
                        sum_q <= sum_d;
                        if (sum_d == '0) begin
                            zf_q    <= 1'b1;
                            state_q <= DONE;
                        end else if (sum_d[MAN_W+1] || !sum_d[MAN_W]) begin
                            state_q <= NORM;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                    NORM: begin
                        sum_q <= norm_sum_d;
                        exp_q <= norm_exp_d;
                        if (sum_q[MAN_W+1] && (exp_q == 8'd254)) begin
                            ovf_q   <= 1'b1;
                            state_q <= DONE;
                        end else if (!sum_q[MAN_W+1] && (exp_q == 8'd1)) begin
                            zf_q    <= 1'b1;
                            state_q <= DONE;
                        end else if (norm_sum_d[MAN_W]) begin
                            state_q <= DONE;
                        end
                    end
                    DONE: begin
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        overflow_q <= ovf_q;
                        zero_q     <= zf_q && !ovf_q;
                        if (ovf_q)
                            result_q <= {sign_q, 8'hFF, 23'h0};
                        else if (zf_q)
                            result_q <= '0;
                        else
                            result_q <= {sign_q, exp_q, sum_q[MAN_W-1:0]};
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;
    assign estado   = state_q;

endmodule

`default_nettype wire

// File: tb/tb_restador_punto_flotante.sv
// ============================================================================
// Module      : tb_restador_punto_flotante
// Description : Directed table-driven bench for the float subtractor plus
//               abort / ignored-start / held-result sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_restador_punto_flotante;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;
    logic        zero;
    logic [2:0]  estado;
`ifdef MANUAL_STEP_EN
    logic        step = 1'b1;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    restador_punto_flotante #(.N(32)) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef MANUAL_STEP_EN
        .step     (step),
`endif
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow),
        .zero     (zero),
        .estado   (estado)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ov;
        logic        z;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issues one start pulse, then waits for done; samples on falling edges.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                          output int lat, output int pw, output logic busy1);
        @(negedge clk);
        a = ta;
        b = tb_v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        busy1 = busy;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        pw = 0;
        while (done && pw < 5) begin
            pw++;
            @(negedge clk);
        end
    endtask

    int   lat;
    int   pw;
    logic busy1;

    initial begin
        vecs[0]  = '{32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 5};
        vecs[1]  = '{32'h3F800000, 32'hBF800000, 32'h40000000, 1'b0, 1'b0, 5};
        vecs[2]  = '{32'h3F800000, 32'h40000000, 32'hBF800000, 1'b0, 1'b0, 6};
        vecs[3]  = '{32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b1, 4};
        vecs[4]  = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1, 1'b0, 5};
        vecs[5]  = '{32'h4B000000, 32'h3F800000, 32'h4AFFFFFE, 1'b0, 1'b0, 28};
        vecs[6]  = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1, 1'b0, 3};
        vecs[7]  = '{32'h00000001, 32'h3F800000, 32'hBF800000, 1'b0, 1'b0, 29};
        vecs[8]  = '{32'h40000000, 32'h3FC00000, 32'h3F000000, 1'b0, 1'b0, 7};
        vecs[9]  = '{32'h00800000, 32'h00C00000, 32'h00000000, 1'b0, 1'b1, 5};
        vecs[10] = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 4};

        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset busy",     {31'd0, busy},     32'd0);
        check("reset done",     {31'd0, done},     32'd0);
        check("reset result",   result,            32'd0);
        check("reset overflow", {31'd0, overflow}, 32'd0);
        check("reset zero",     {31'd0, zero},     32'd0);
        check("reset estado",   {29'd0, estado},   32'd0);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat, pw, busy1);
            check($sformatf("v%0d result", i),   result,            vecs[i].res);
            check($sformatf("v%0d overflow", i), {31'd0, overflow}, {31'd0, vecs[i].ov});
            check($sformatf("v%0d zero", i),     {31'd0, zero},     {31'd0, vecs[i].z});
            check($sformatf("v%0d latency", i),  lat,               vecs[i].lat);
            check($sformatf("v%0d done width", i), pw,              32'd1);
            check($sformatf("v%0d busy", i),     {31'd0, busy1},    32'd1);
        end

        // Second start mid-ALIGN with different operands must be ignored.
        @(negedge clk);
        a = 32'h4B000000;
        b = 32'h3F800000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("seqA estado align", {29'd0, estado}, 32'd2);
        a = 32'h3F800000;
        b = 32'h3F800000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int k = 6; k <= 100; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check("seqA latency", lat, 32'd28);
        check("seqA result", result, 32'h4AFFFFFE);
        repeat (3) @(negedge clk);
        check("seqA result held", result, 32'h4AFFFFFE);

        // Asynchronous reset mid-ALIGN.
        @(negedge clk);
        a = 32'h4B000000;
        b = 32'h3F800000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("seqB estado align", {29'd0, estado}, 32'd2);
        check("seqB busy before", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("seqB busy abort",   {31'd0, busy},   32'd0);
        check("seqB estado abort", {29'd0, estado}, 32'd0);
        check("seqB result abort", result,          32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(32'h40400000, 32'h3F800000, lat, pw, busy1);
        check("seqB recover result", result, 32'h40000000);
        check("seqB recover latency", lat, 32'd5);

`ifdef MANUAL_STEP_EN
        @(negedge clk);
        step = 1'b0;
        a = 32'h40400000;
        b = 32'h3F800000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("step frozen estado", {29'd0, estado}, 32'd1);
        step = 1'b1;
        lat = -1;
        for (int k = 0; k < 100; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check("step resume result", result, 32'h40000000);
        check("step resume done seen", {31'd0, (lat >= 0)}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
